// File: rtl/jtag_tap_ir_decode.sv
// JTAG TAP instruction register with one-hot decode and scan-length check.
// Optional parity bit on the IR scan: define JTAG_IR_PARITY_EN.
module jtag_tap_ir_decode #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] INSN_IDCODE = WIDTH'(2),
  parameter logic [WIDTH-1:0] INSN_BYPASS = '1,
  parameter logic [WIDTH-1:0] USER_BASE   = WIDTH'(8),
  parameter int               NUM_USER    = 4,
  parameter int               CNT_W       = 6
) (
  input  logic                tck,
  input  logic                trstn,
  input  logic                tdi,
  input  logic                state_test_logic_reset,
  input  logic                state_capture_ir,
  input  logic                state_shift_ir,
  input  logic                state_update_ir,
  input  logic [WIDTH-3:0]    status_in,
  output logic                insn_tdo,
  output logic [WIDTH-1:0]    ir_out,
  output logic                sel_idcode,
  output logic                sel_bypass,
  output logic [NUM_USER-1:0] sel_user,
  output logic                ir_len_err
`ifdef JTAG_IR_PARITY_EN
  ,
  output logic                ir_par_err
`endif
);

`ifdef JTAG_IR_PARITY_EN
  localparam int SRW = WIDTH + 1;
`else
  localparam int SRW = WIDTH;
`endif

  localparam logic [CNT_W-1:0] SCAN_LEN = CNT_W'(SRW);

  logic [SRW-1:0]   sr_q, sr_d, cap_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             len_q, len_d;
  logic             par_q, par_d;
  logic             tlr;

  assign tlr = state_test_logic_reset;

`ifdef JTAG_IR_PARITY_EN
  assign cap_w = {1'b0, status_in, 2'b01};
`else
  assign cap_w = {status_in, 2'b01};
`endif

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (tlr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (state_capture_ir) begin
      sr_d  = cap_w;
      cnt_d = '0;
    end else if (state_shift_ir) begin
      sr_d = {tdi, sr_q[SRW-1:1]};
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge tck) begin
    if (!trstn) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // cnt==0 means Capture-Exit1-Update with no shift: keep the old insn
  always_comb begin
    ir_d  = ir_q;
    len_d = len_q;
    par_d = par_q;
    if (tlr) begin
      ir_d  = INSN_IDCODE;
      len_d = 1'b0;
      par_d = 1'b0;
    end else if (state_update_ir && cnt_q != '0) begin
      if (cnt_q == SCAN_LEN) begin
`ifdef JTAG_IR_PARITY_EN
        if (^sr_q) begin
          ir_d = sr_q[WIDTH-1:0];
        end else begin
          ir_d  = INSN_BYPASS;
          par_d = 1'b1;
        end
`else
        ir_d = sr_q[WIDTH-1:0];
`endif
      end else begin
        ir_d  = INSN_BYPASS;
        len_d = 1'b1;
      end
    end
  end

  always_ff @(negedge tck) begin
    if (!trstn) begin
      ir_q  <= INSN_IDCODE;
      len_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      len_q <= len_d;
      par_q <= par_d;
    end
  end

  logic                id_hit, bp_hit;
  logic [NUM_USER-1:0] user_hit;

  assign id_hit = (ir_q == INSN_IDCODE);
  assign bp_hit = (ir_q == INSN_BYPASS);

  for (genvar i = 0; i < NUM_USER; i++) begin : g_user
    localparam logic [WIDTH-1:0] OP = USER_BASE + WIDTH'(i);
    assign user_hit[i] = (ir_q == OP);
  end

  // IDCODE wins over an overlapping user opcode, BYPASS over the rest
  assign sel_idcode = id_hit;
  assign sel_user   = user_hit & {NUM_USER{~id_hit & ~bp_hit}};
  assign sel_bypass = ~id_hit & (bp_hit | ~(|user_hit));

  assign insn_tdo   = sr_q[0];
  assign ir_out     = ir_q;
  assign ir_len_err = len_q;
`ifdef JTAG_IR_PARITY_EN
  assign ir_par_err = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule
